// File: rtl/uart_fifo_bridge.sv
// Line-buffering bridge: UART RX bytes are written into the FIFO, and a complete
// line (or a full FIFO) is drained byte-by-byte to the UART transmitter.
module uart_fifo_bridge #(
    parameter int                   DATA_BITS    = 8,
    parameter logic [DATA_BITS-1:0] TERMINATOR   = 8'h0D,
    parameter int                   ADDRESS_BITS = 10
) (
    input  logic                 clk_in,
    input  logic                 n_rst,
    input  logic                 uart_rx_valid_in,
    input  logic [DATA_BITS-1:0] uart_rx_data_in,
    input  logic                 fifo_empty_in,
    input  logic                 fifo_full_in,
    input  logic [DATA_BITS-1:0] fifo_rd_data_in,
    input  logic                 uart_tx_ready_in,
    output logic                 fifo_wr_en,
    output logic [DATA_BITS-1:0] fifo_wr_data_out,
    output logic                 fifo_rd_en,
    output logic                 uart_tx_en,
    output logic [DATA_BITS-1:0] uart_tx_data_out,
    output logic                 overflow_out,
    output logic                 busy_out
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_LOAD      = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_ACK  = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_t;

    localparam logic [ADDRESS_BITS:0] LINE_ZERO = {(ADDRESS_BITS+1){1'b0}};
    localparam logic [ADDRESS_BITS:0] LINE_ONE  = {{ADDRESS_BITS{1'b0}}, 1'b1};
    localparam logic [ADDRESS_BITS:0] LINE_MAX  = {(ADDRESS_BITS+1){1'b1}};

    logic [2:0]              rx_sync_r;
    logic [2:0]              tx_sync_r;
    logic                    rx_pulse_s;
    logic                    tx_ready_s;
    logic                    tx_done_s;

    logic                    wr_en_nx_s;
    logic [DATA_BITS-1:0]    wr_data_nx_s;
    logic                    overflow_nx_s;
    logic                    line_inc_s;
    logic                    line_dec_s;
    logic [ADDRESS_BITS:0]   line_count_r;
    logic [ADDRESS_BITS:0]   line_count_nx_s;

    state_t                  state_r;
    state_t                  state_nx_s;
    logic                    rd_en_nx_s;
    logic                    tx_en_nx_s;
    logic [DATA_BITS-1:0]    tx_data_nx_s;
    logic                    busy_nx_s;

    // Two-flop synchronisers for the slow-domain levels, third stage for edge detection.
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            rx_sync_r <= 3'b000;
            tx_sync_r <= 3'b000;
        end else begin
            rx_sync_r <= {rx_sync_r[1:0], uart_rx_valid_in};
            tx_sync_r <= {tx_sync_r[1:0], uart_tx_ready_in};
        end
    end

    assign rx_pulse_s = rx_sync_r[1] & ~rx_sync_r[2];
    assign tx_ready_s = tx_sync_r[1];
    assign tx_done_s  = tx_sync_r[1] & ~tx_sync_r[2];

    // RX path: one write per valid rising edge; bytes arriving on a full FIFO are dropped.
    always_comb begin
        wr_en_nx_s    = 1'b0;
        wr_data_nx_s  = fifo_wr_data_out;
        overflow_nx_s = overflow_out;
        line_inc_s    = 1'b0;
        if (rx_pulse_s) begin
            if (fifo_full_in) begin
                overflow_nx_s = 1'b1;
            end else begin
                wr_en_nx_s   = 1'b1;
                wr_data_nx_s = uart_rx_data_in;
                line_inc_s   = (uart_rx_data_in == TERMINATOR);
            end
        end else begin
            wr_en_nx_s = 1'b0;
        end
    end

    // Complete-line counter: saturating, never underflows, inc+dec cancel.
    always_comb begin
        line_count_nx_s = line_count_r;
        case ({line_inc_s, line_dec_s})
            2'b10: begin
                if (line_count_r != LINE_MAX) begin
                    line_count_nx_s = line_count_r + LINE_ONE;
                end else begin
                    line_count_nx_s = line_count_r;
                end
            end
            2'b01: begin
                if (line_count_r != LINE_ZERO) begin
                    line_count_nx_s = line_count_r - LINE_ONE;
                end else begin
                    line_count_nx_s = line_count_r;
                end
            end
            default: line_count_nx_s = line_count_r;
        endcase
    end

    // Drain FSM next-state and next-output logic.
    always_comb begin
        state_nx_s   = state_r;
        rd_en_nx_s   = 1'b0;
        tx_en_nx_s   = 1'b0;
        tx_data_nx_s = uart_tx_data_out;
        line_dec_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (((line_count_r != LINE_ZERO) || fifo_full_in) && !fifo_empty_in) begin
                    state_nx_s = ST_READ;
                    rd_en_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_READ: state_nx_s = ST_LOAD;
            ST_LOAD: begin
                tx_data_nx_s = fifo_rd_data_in;
                state_nx_s   = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready_s) begin
                    tx_en_nx_s = 1'b1;
                    state_nx_s = ST_WAIT_ACK;
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_WAIT_ACK: begin
                // Hold the request until the TX core has visibly gone busy.
                if (!tx_ready_s) begin
                    state_nx_s = ST_WAIT_DONE;
                end else begin
                    tx_en_nx_s = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done_s) begin
                    if (uart_tx_data_out == TERMINATOR) begin
                        line_dec_s = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else if (!fifo_empty_in) begin
                        rd_en_nx_s = 1'b1;
                        state_nx_s = ST_READ;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_WAIT_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // State, line counter and registered outputs.
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            state_r          <= ST_IDLE;
            line_count_r     <= LINE_ZERO;
            fifo_wr_en       <= 1'b0;
            fifo_wr_data_out <= {DATA_BITS{1'b0}};
            overflow_out     <= 1'b0;
            fifo_rd_en       <= 1'b0;
            uart_tx_en       <= 1'b0;
            uart_tx_data_out <= {DATA_BITS{1'b0}};
            busy_out         <= 1'b0;
        end else begin
            state_r          <= state_nx_s;
            line_count_r     <= line_count_nx_s;
            fifo_wr_en       <= wr_en_nx_s;
            fifo_wr_data_out <= wr_data_nx_s;
            overflow_out     <= overflow_nx_s;
            fifo_rd_en       <= rd_en_nx_s;
            uart_tx_en       <= tx_en_nx_s;
            uart_tx_data_out <= tx_data_nx_s;
            busy_out         <= busy_nx_s;
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: behavioural FIFO and TX models around the DUT,
// with a scoreboard of bytes expected at the transmitter.
module tb_uart_fifo_bridge;

    localparam int TX_CYCLES = 160;

    logic       clk_in;
    logic       n_rst;
    logic       uart_rx_valid_in;
    logic [7:0] uart_rx_data_in;
    logic       fifo_empty_in;
    logic       fifo_full_in;
    logic [7:0] fifo_rd_data_in;
    logic       uart_tx_ready_in;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data_out;
    logic       fifo_rd_en;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data_out;
    logic       overflow_out;
    logic       busy_out;

    int         n_checks = 0;
    int         n_pass   = 0;

    logic [7:0] fifo_q[$];
    int         fifo_cap = 16;
    int         wr_count = 0;
    int         rd_count = 0;

    logic [7:0] exp_tx[$];
    int         tx_left     = 0;
    int         tx_accepted = 0;
    logic [7:0] tx_cur      = 8'h00;
    bit         tx_hold     = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         hold;
        logic       exp_busy;
    } rx_vec_t;

    rx_vec_t vecs[8];

    uart_fifo_bridge dut (
        .clk_in           (clk_in),
        .n_rst            (n_rst),
        .uart_rx_valid_in (uart_rx_valid_in),
        .uart_rx_data_in  (uart_rx_data_in),
        .fifo_empty_in    (fifo_empty_in),
        .fifo_full_in     (fifo_full_in),
        .fifo_rd_data_in  (fifo_rd_data_in),
        .uart_tx_ready_in (uart_tx_ready_in),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data_out (fifo_wr_data_out),
        .fifo_rd_en       (fifo_rd_en),
        .uart_tx_en       (uart_tx_en),
        .uart_tx_data_out (uart_tx_data_out),
        .overflow_out     (overflow_out),
        .busy_out         (busy_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #20 clk_in = ~clk_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model: strobes sampled mid-cycle, applied just after the edge.
    initial begin
        logic       w_s, r_s, fe_s, ff_s;
        logic [7:0] wd_s;
        fifo_empty_in   = 1'b1;
        fifo_full_in    = 1'b0;
        fifo_rd_data_in = 8'h00;
        forever begin
            @(negedge clk_in);
            w_s  = fifo_wr_en;
            r_s  = fifo_rd_en;
            wd_s = fifo_wr_data_out;
            fe_s = fifo_empty_in;
            ff_s = fifo_full_in;
            @(posedge clk_in);
            #1;
            if (!n_rst) begin
                fifo_q.delete();
            end else begin
                if (r_s) begin
                    check("rd_while_empty", {31'd0, fe_s}, 32'd0);
                    rd_count++;
                    if (fifo_q.size() > 0) fifo_rd_data_in = fifo_q.pop_front();
                end
                if (w_s) begin
                    check("wr_while_full", {31'd0, ff_s}, 32'd0);
                    wr_count++;
                    if (fifo_q.size() < fifo_cap) fifo_q.push_back(wd_s);
                end
            end
            fifo_empty_in = (fifo_q.size() == 0);
            fifo_full_in  = (fifo_q.size() >= fifo_cap);
        end
    end

    // TX model: accepts a byte when tx_en is seen while idle, then stays busy TX_CYCLES.
    initial begin
        logic [31:0] e;
        uart_tx_ready_in = 1'b1;
        forever begin
            @(negedge clk_in);
            if (!n_rst) begin
                tx_left          = 0;
                uart_tx_ready_in = !tx_hold;
            end else if (tx_left > 0) begin
                tx_left--;
                if (tx_left == 0) uart_tx_ready_in = 1'b1;
            end else if (tx_hold) begin
                uart_tx_ready_in = 1'b0;
            end else if (uart_tx_en && uart_tx_ready_in) begin
                tx_cur = uart_tx_data_out;
                tx_accepted++;
                if (exp_tx.size() > 0) e = {24'd0, exp_tx.pop_front()};
                else e = 32'h100;
                check("tx_byte", {24'd0, tx_cur}, e);
                tx_left          = TX_CYCLES;
                uart_tx_ready_in = 1'b0;
            end else begin
                uart_tx_ready_in = 1'b1;
            end
        end
    end

    task automatic send_rx(input logic [7:0] d, input int hold, input logic exp_wr);
        int wc0;
        @(negedge clk_in);
        wc0              = wr_count;
        uart_rx_data_in  = d;
        uart_rx_valid_in = 1'b1;
        if (exp_wr) exp_tx.push_back(d);
        @(posedge clk_in);
        @(posedge clk_in);
        #1 check("wr_not_early", {31'd0, fifo_wr_en}, 32'd0);
        @(posedge clk_in);
        #1 check("wr_strobe", {31'd0, fifo_wr_en}, {31'd0, exp_wr});
        if (exp_wr) check("wr_data", {24'd0, fifo_wr_data_out}, {24'd0, d});
        repeat (hold) @(posedge clk_in);
        @(negedge clk_in);
        uart_rx_valid_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1 check("wr_count_per_valid", wr_count - wc0, {31'd0, exp_wr});
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk_in);
            if (!busy_out && tx_left == 0 && exp_tx.size() == 0) break;
        end
        check("idle_busy", {31'd0, busy_out}, 32'd0);
        check("idle_scoreboard_empty", exp_tx.size(), 32'd0);
        check("idle_fifo_empty", fifo_q.size(), 32'd0);
    endtask

    initial begin
        int acc0, r0, w0, hi;
        bit found;

        vecs[0] = '{8'h41, 2, 1'b0};
        vecs[1] = '{8'h42, 2, 1'b0};
        vecs[2] = '{8'h0D, 2, 1'b1};
        vecs[3] = '{8'h00, 2, 1'b0};
        vecs[4] = '{8'hFF, 2, 1'b0};
        vecs[5] = '{8'h0D, 2, 1'b1};
        vecs[6] = '{8'h55, 50, 1'b0};
        vecs[7] = '{8'h0D, 2, 1'b1};

        n_rst            = 1'b0;
        uart_rx_valid_in = 1'b0;
        uart_rx_data_in  = 8'h00;
        repeat (4) @(posedge clk_in);
        #1;
        check("reset_wr_en",   {31'd0, fifo_wr_en},       32'd0);
        check("reset_wr_data", {24'd0, fifo_wr_data_out}, 32'd0);
        check("reset_rd_en",   {31'd0, fifo_rd_en},       32'd0);
        check("reset_tx_en",   {31'd0, uart_tx_en},       32'd0);
        check("reset_tx_data", {24'd0, uart_tx_data_out}, 32'd0);
        check("reset_overflow",{31'd0, overflow_out},     32'd0);
        check("reset_busy",    {31'd0, busy_out},         32'd0);
        @(negedge clk_in);
        n_rst = 1'b1;
        repeat (3) @(posedge clk_in);

        // Table: lines 'A','B',CR / 00,FF,CR / long-valid 55,CR
        for (int i = 0; i < 8; i++) begin
            send_rx(vecs[i].data, vecs[i].hold, 1'b1);
            check("busy_after_rx", {31'd0, busy_out}, {31'd0, vecs[i].exp_busy});
            if (vecs[i].exp_busy) wait_idle(3000);
        end

        // Terminator of line 2 lands in the same cycle line 1's terminator completes.
        acc0 = tx_accepted;
        send_rx(8'h50, 2, 1'b1);
        send_rx(8'h0D, 2, 1'b1);
        send_rx(8'h51, 2, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_in);
            if (tx_accepted == acc0 + 2 && tx_left == 1) begin
                found = 1'b1;
                break;
            end
        end
        check("concurrent_align", {31'd0, found}, 32'd1);
        if (found) begin
            @(negedge clk_in);
            r0               = rd_count;
            w0               = wr_count;
            uart_rx_data_in  = 8'h0D;
            uart_rx_valid_in = 1'b1;
            exp_tx.push_back(8'h0D);
            repeat (8) @(posedge clk_in);
            #2;
            check("concurrent_next_line_read", rd_count - r0, 32'd1);
            check("concurrent_write", wr_count - w0, 32'd1);
            @(negedge clk_in);
            uart_rx_valid_in = 1'b0;
        end
        wait_idle(3000);

        // Partial line stays buffered.
        r0 = rd_count;
        send_rx(8'h58, 2, 1'b1);
        send_rx(8'h59, 2, 1'b1);
        hi = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk_in);
            if (uart_tx_en) hi++;
        end
        check("partial_no_tx_en", hi, 32'd0);
        check("partial_no_read", rd_count - r0, 32'd0);
        check("partial_not_busy", {31'd0, busy_out}, 32'd0);
        send_rx(8'h0D, 2, 1'b1);
        wait_idle(3000);

        // Fill a 4-byte FIFO while a CR is transmitting, then overflow it.
        fifo_cap = 4;
        r0 = rd_count;
        send_rx(8'h0D, 2, 1'b1);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_in);
            if (tx_left > 0) break;
        end
        send_rx(8'h11, 2, 1'b1);
        send_rx(8'h12, 2, 1'b1);
        send_rx(8'h13, 2, 1'b1);
        send_rx(8'h14, 2, 1'b1);
        check("fifo_full_reached", {31'd0, fifo_full_in}, 32'd1);
        send_rx(8'h15, 2, 1'b0);
        check("overflow_set", {31'd0, overflow_out}, 32'd1);
        wait_idle(3000);
        check("overflow_sticky", {31'd0, overflow_out}, 32'd1);
        check("full_drain_reads", rd_count - r0, 32'd5);
        fifo_cap = 16;

        // Reset while stuck in SEND.
        tx_hold = 1'b1;
        repeat (3) @(negedge clk_in);
        send_rx(8'h52, 2, 1'b1);
        send_rx(8'h0D, 2, 1'b1);
        repeat (5) @(posedge clk_in);
        #1;
        check("send_busy", {31'd0, busy_out}, 32'd1);
        check("send_tx_en_low", {31'd0, uart_tx_en}, 32'd0);
        check("send_tx_data", {24'd0, uart_tx_data_out}, 32'h52);
        @(negedge clk_in);
        n_rst = 1'b0;
        #1;
        check("async_rst_wr_en",   {31'd0, fifo_wr_en},       32'd0);
        check("async_rst_wr_data", {24'd0, fifo_wr_data_out}, 32'd0);
        check("async_rst_rd_en",   {31'd0, fifo_rd_en},       32'd0);
        check("async_rst_tx_en",   {31'd0, uart_tx_en},       32'd0);
        check("async_rst_tx_data", {24'd0, uart_tx_data_out}, 32'd0);
        check("async_rst_overflow",{31'd0, overflow_out},     32'd0);
        check("async_rst_busy",    {31'd0, busy_out},         32'd0);
        exp_tx.delete();
        repeat (3) @(negedge clk_in);
        n_rst   = 1'b1;
        tx_hold = 1'b0;
        r0 = rd_count;
        w0 = wr_count;
        repeat (20) @(posedge clk_in);
        #2;
        check("post_rst_no_write", wr_count - w0, 32'd0);
        check("post_rst_no_read", rd_count - r0, 32'd0);
        check("post_rst_idle", {31'd0, busy_out}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
